// File: rtl/seg_display_scan.sv
// Time-multiplexed 4-digit 7-segment driver for a packed {min,sec} word.
// The word is snapshotted once per scan frame; supports blank, blink and leading-zero suppression.
module seg_display_scan #(
   parameter int SCAN_DIV     = 1000,
   parameter int BLINK_FRAMES = 64
) (
   input  logic        clk,
   input  logic        nrst,
   input  logic [11:0] time_to_decode,
   input  logic        blank,
   input  logic        blink_en,
   input  logic        lz_blank,
   output logic [6:0]  seg,
   output logic [3:0]  digit_en,
   output logic        dp,
   output logic        frame_start
);

   localparam int CW = $clog2(SCAN_DIV);
   localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [CW-1:0] CNT_MAX   = CW'(SCAN_DIV - 1);
   localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_FRAMES - 1);

   function automatic logic [3:0] ones_of(input logic [5:0] v);
      logic [5:0] r;
      r = v % 6'd10;
      return r[3:0];
   endfunction

   function automatic logic [3:0] tens_of(input logic [5:0] v);
      logic [5:0] q;
      q = v / 6'd10;
      return q[3:0];
   endfunction

   function automatic logic [6:0] seg_of(input logic [3:0] d);
      case (d)
         4'd0:    return 7'b0111111;
         4'd1:    return 7'b0000110;
         4'd2:    return 7'b1011011;
         4'd3:    return 7'b1001111;
         4'd4:    return 7'b1100110;
         4'd5:    return 7'b1101101;
         4'd6:    return 7'b1111101;
         4'd7:    return 7'b0000111;
         4'd8:    return 7'b1111111;
         4'd9:    return 7'b1101111;
         default: return 7'b0000000;
      endcase
   endfunction

   logic [CW-1:0] count_r;
   logic [1:0]    idx_r;
   logic [11:0]   snap_r;
   logic          started_r;
   logic [BW-1:0] blink_cnt_r;
   logic          phase_r;

   logic          tick_s;
   logic          wrap_s;
   logic [1:0]    idx_next_s;
   logic [11:0]   snap_next_s;
   logic          started_next_s;
   logic [BW-1:0] blink_cnt_next_s;
   logic          phase_next_s;
   logic [3:0]    digit_s;
   logic [6:0]    seg_s;
   logic [3:0]    en_s;
   logic          dp_s;

   assign tick_s         = (count_r == CNT_MAX);
   assign wrap_s         = tick_s && (idx_r == 2'd3);
   assign idx_next_s     = tick_s ? idx_r + 2'd1 : idx_r;
   assign snap_next_s    = wrap_s ? time_to_decode : snap_r;
   assign started_next_s = started_r | tick_s;

   // Blink counter advances once per frame; the phase flips on the same edge as the frame tick.
   always_comb begin
      blink_cnt_next_s = blink_cnt_r;
      phase_next_s     = phase_r;
      if (!blink_en) begin
         blink_cnt_next_s = '0;
         phase_next_s     = 1'b0;
      end else if (wrap_s) begin
         if (blink_cnt_r == BLINK_MAX) begin
            blink_cnt_next_s = '0;
            phase_next_s     = ~phase_r;
         end else begin
            blink_cnt_next_s = blink_cnt_r + BW'(1);
         end
      end else begin
         blink_cnt_next_s = blink_cnt_r;
      end
   end

   // Outputs are computed from next-state values so digit 0 of a frame shows the fresh snapshot.
   always_comb begin
      case (idx_next_s)
         2'd0:    digit_s = ones_of(snap_next_s[5:0]);
         2'd1:    digit_s = tens_of(snap_next_s[5:0]);
         2'd2:    digit_s = ones_of(snap_next_s[11:6]);
         2'd3:    digit_s = tens_of(snap_next_s[11:6]);
         default: digit_s = 4'd0;
      endcase
      en_s = 4'b0001 << idx_next_s;
      dp_s = (idx_next_s == 2'd2);
      if (lz_blank && (idx_next_s == 2'd3) && (digit_s == 4'd0)) begin
         seg_s = 7'b0000000;
      end else begin
         seg_s = seg_of(digit_s);
      end
      if (blank || phase_next_s || !started_next_s) begin
         seg_s = 7'b0000000;
         en_s  = 4'b0000;
         dp_s  = 1'b0;
      end else begin
         dp_s  = dp_s;
      end
   end

   // Scan state, snapshot, blink state and registered outputs.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         count_r     <= '0;
         idx_r       <= 2'd3;
         snap_r      <= 12'd0;
         started_r   <= 1'b0;
         blink_cnt_r <= '0;
         phase_r     <= 1'b0;
         seg         <= 7'd0;
         digit_en    <= 4'd0;
         dp          <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         count_r     <= tick_s ? '0 : count_r + CW'(1);
         idx_r       <= idx_next_s;
         snap_r      <= snap_next_s;
         started_r   <= started_next_s;
         blink_cnt_r <= blink_cnt_next_s;
         phase_r     <= phase_next_s;
         seg         <= seg_s;
         digit_en    <= en_s;
         dp          <= dp_s;
         frame_start <= wrap_s;
      end
   end

endmodule

// File: tb/tb_seg_display_scan.sv
// Scoreboard bench for seg_display_scan with SCAN_DIV=4, BLINK_FRAMES=2.
// Expected digit slots are queued as stimulus is applied and popped as each slot is sampled.
module tb_seg_display_scan;

   localparam int SD = 4;

   logic        clk = 1'b0;
   logic        nrst = 1'b0;
   logic [11:0] time_to_decode = 12'd0;
   logic        blank = 1'b0;
   logic        blink_en = 1'b0;
   logic        lz_blank = 1'b0;
   logic [6:0]  seg;
   logic [3:0]  digit_en;
   logic        dp;
   logic        frame_start;

   int total = 0;
   int bad = 0;
   int fs_seen = 0;
   logic [11:0] sb[$];
   logic [11:0] exp_v;

   seg_display_scan #(.SCAN_DIV(SD), .BLINK_FRAMES(2)) dut (
      .clk(clk), .nrst(nrst), .time_to_decode(time_to_decode), .blank(blank),
      .blink_en(blink_en), .lz_blank(lz_blank), .seg(seg), .digit_en(digit_en),
      .dp(dp), .frame_start(frame_start)
   );

   always #5 clk = ~clk;

   function automatic logic [6:0] seg_tab(input int d);
      case (d)
         0: return 7'b0111111;
         1: return 7'b0000110;
         2: return 7'b1011011;
         3: return 7'b1001111;
         4: return 7'b1100110;
         5: return 7'b1101101;
         6: return 7'b1111101;
         7: return 7'b0000111;
         8: return 7'b1111111;
         9: return 7'b1101111;
         default: return 7'b0000000;
      endcase
   endfunction

   function automatic logic [11:0] mk(input logic [3:0] en, input int d, input logic p);
      return {en, seg_tab(d), p};
   endfunction

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (frame_start === 1'b1) fs_seen++;
      end
   endtask

   task automatic wait_fs(input string name);
      int k;
      k = 0;
      step(1);
      while (frame_start !== 1'b1 && k < 64) begin
         step(1);
         k++;
      end
      total++;
      if (frame_start !== 1'b1) begin
         bad++;
         $display("FAIL %s frame_start timeout got=%b exp=1", name, frame_start);
      end
   endtask

   task automatic test_reset;
      nrst = 1'b0;
      time_to_decode = 12'h322;
      #1;
      repeat (2) @(negedge clk);
      total++;
      if ({digit_en, seg, dp, frame_start} !== 13'd0) begin
         bad++;
         $display("FAIL reset_outputs got=%h exp=0", {digit_en, seg, dp, frame_start});
      end
      nrst = 1'b1;
      fs_seen = 0;
      for (int i = 0; i < 4; i++) begin
         total++;
         if ({digit_en, seg, dp, frame_start} !== 13'd0) begin
            bad++;
            $display("FAIL post_reset_idle cycle%0d got=%h exp=0", i, {digit_en, seg, dp, frame_start});
         end
         step(1);
      end
      total++;
      if (frame_start !== 1'b1 || fs_seen !== 1) begin
         bad++;
         $display("FAIL first_frame_start got=%b seen=%0d exp=1 seen=1", frame_start, fs_seen);
      end
   endtask

   task automatic test_scan;
      sb.push_back(mk(4'b0001, 4, 1'b0));
      sb.push_back(mk(4'b0010, 3, 1'b0));
      sb.push_back(mk(4'b0100, 2, 1'b1));
      sb.push_back(mk(4'b1000, 1, 1'b0));
      fs_seen = 0;
      for (int k = 0; k < 4; k++) begin
         exp_v = sb.pop_front();
         total++;
         if ({digit_en, seg, dp} !== exp_v) begin
            bad++;
            $display("FAIL scan_1234 slot%0d got=%h exp=%h", k, {digit_en, seg, dp}, exp_v);
         end
         step(SD);
      end
      total++;
      if (frame_start !== 1'b1 || fs_seen !== 1) begin
         bad++;
         $display("FAIL frame_period got=%b seen=%0d exp=1 seen=1", frame_start, fs_seen);
      end
   endtask

   task automatic test_anti_tear;
      sb.push_back(mk(4'b0001, 4, 1'b0));
      sb.push_back(mk(4'b0010, 3, 1'b0));
      sb.push_back(mk(4'b0100, 2, 1'b1));
      sb.push_back(mk(4'b1000, 1, 1'b0));
      sb.push_back(mk(4'b0001, 0, 1'b0));
      for (int k = 0; k < 5; k++) begin
         if (k == 1) time_to_decode = 12'h000;
         exp_v = sb.pop_front();
         total++;
         if ({digit_en, seg, dp} !== exp_v) begin
            bad++;
            $display("FAIL anti_tear slot%0d got=%h exp=%h", k, {digit_en, seg, dp}, exp_v);
         end
         step(SD);
      end
   endtask

   task automatic test_limits;
      time_to_decode = 12'hFFF;
      wait_fs("limits_63");
      sb.push_back(mk(4'b0001, 3, 1'b0));
      sb.push_back(mk(4'b0010, 6, 1'b0));
      sb.push_back(mk(4'b0100, 3, 1'b1));
      sb.push_back(mk(4'b1000, 6, 1'b0));
      for (int k = 0; k < 4; k++) begin
         exp_v = sb.pop_front();
         total++;
         if ({digit_en, seg, dp} !== exp_v) begin
            bad++;
            $display("FAIL limits_63 slot%0d got=%h exp=%h", k, {digit_en, seg, dp}, exp_v);
         end
         step(SD);
      end
      time_to_decode = {6'd5, 6'd7};
      lz_blank = 1'b1;
      wait_fs("lz_blank");
      sb.push_back(mk(4'b0001, 7, 1'b0));
      sb.push_back(mk(4'b0010, 0, 1'b0));
      sb.push_back(mk(4'b0100, 5, 1'b1));
      sb.push_back(mk(4'b1000, 10, 1'b0));
      for (int k = 0; k < 4; k++) begin
         exp_v = sb.pop_front();
         total++;
         if ({digit_en, seg, dp} !== exp_v) begin
            bad++;
            $display("FAIL lz_blank slot%0d got=%h exp=%h", k, {digit_en, seg, dp}, exp_v);
         end
         step(SD);
      end
      lz_blank = 1'b0;
   endtask

   task automatic test_blink;
      logic vis[6];
      vis = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      blink_en = 1'b1;
      for (int f = 0; f < 6; f++) begin
         sb.push_back(vis[f] ? mk(4'b0001, 7, 1'b0) : 12'd0);
         wait_fs("blink");
         exp_v = sb.pop_front();
         total++;
         if ({digit_en, seg, dp} !== exp_v) begin
            bad++;
            $display("FAIL blink frame%0d got=%h exp=%h", f + 1, {digit_en, seg, dp}, exp_v);
         end
      end
      sb.push_back(12'd0);
      sb.push_back(mk(4'b0010, 0, 1'b0));
      step(SD + 1);
      for (int k = 0; k < 2; k++) begin
         exp_v = sb.pop_front();
         total++;
         if ({digit_en, seg, dp} !== exp_v) begin
            bad++;
            $display("FAIL blink_release chk%0d got=%h exp=%h", k, {digit_en, seg, dp}, exp_v);
         end
         if (k == 0) begin
            blink_en = 1'b0;
            step(1);
         end
      end
   endtask

   task automatic test_blank;
      int gaps[6];
      gaps = '{1, 1, 1, 1, 3, 4};
      wait_fs("blank_sync");
      sb.push_back(12'd0);
      sb.push_back(12'd0);
      sb.push_back(12'd0);
      sb.push_back(mk(4'b0010, 0, 1'b0));
      sb.push_back(mk(4'b0100, 5, 1'b1));
      sb.push_back(mk(4'b1000, 0, 1'b0));
      for (int i = 0; i < 6; i++) begin
         if (i == 0) begin
            step(1);
            blank = 1'b1;
         end
         step(gaps[i]);
         exp_v = sb.pop_front();
         total++;
         if ({digit_en, seg, dp} !== exp_v) begin
            bad++;
            $display("FAIL blank chk%0d got=%h exp=%h", i, {digit_en, seg, dp}, exp_v);
         end
         if (i == 2) blank = 1'b0;
      end
   endtask

   task automatic test_reset_mid;
      time_to_decode = {6'd42, 6'd19};
      #2 nrst = 1'b0;
      #1;
      total++;
      if ({digit_en, seg, dp, frame_start} !== 13'd0) begin
         bad++;
         $display("FAIL async_reset got=%h exp=0", {digit_en, seg, dp, frame_start});
      end
      @(negedge clk);
      nrst = 1'b1;
      fs_seen = 0;
      for (int i = 0; i < 4; i++) begin
         total++;
         if ({digit_en, seg, dp, frame_start} !== 13'd0) begin
            bad++;
            $display("FAIL reset_mid_idle cycle%0d got=%h exp=0", i, {digit_en, seg, dp, frame_start});
         end
         step(1);
      end
      total++;
      if (frame_start !== 1'b1 || fs_seen !== 1) begin
         bad++;
         $display("FAIL reset_mid_fs got=%b seen=%0d exp=1 seen=1", frame_start, fs_seen);
      end
      sb.push_back(mk(4'b0001, 9, 1'b0));
      sb.push_back(mk(4'b0010, 1, 1'b0));
      sb.push_back(mk(4'b0100, 2, 1'b1));
      sb.push_back(mk(4'b1000, 4, 1'b0));
      for (int k = 0; k < 4; k++) begin
         exp_v = sb.pop_front();
         total++;
         if ({digit_en, seg, dp} !== exp_v) begin
            bad++;
            $display("FAIL reset_mid_scan slot%0d got=%h exp=%h", k, {digit_en, seg, dp}, exp_v);
         end
         step(SD);
      end
   endtask

   initial begin
      test_reset();
      test_scan();
      test_anti_tear();
      test_limits();
      test_blink();
      test_blank();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
